// File: rtl/erase_car.sv
// Erases a car's previous footprint by replaying background map pixels to the VGA plot port.
// One map read per cycle; plot requests emerge MEM_LAT cycles later alongside the read data.
module erase_car #(
   parameter int MAP_W   = 160,
   parameter int MAP_H   = 120,
   parameter int MEM_LAT = 2
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iStart,
   input  logic [7:0]  iX,
   input  logic [6:0]  iY,
   input  logic [2:0]  iDir,
   input  logic [8:0]  iMapData,
   output logic [14:0] oMapAddr,
   output logic [7:0]  oX,
   output logic [6:0]  oY,
   output logic [8:0]  oColour,
   output logic        oPlot,
   output logic        oBusy,
   output logic        oDone
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t      state_q;
   logic [7:0]  x0_q;
   logic [6:0]  y0_q;
   logic [2:0]  dir_q;
   logic [3:0]  col_q;
   logic [3:0]  row_q;
   logic [1:0]  drain_q;

   logic        pv_q [MEM_LAT];
   logic [7:0]  px_q [MEM_LAT];
   logic [6:0]  py_q [MEM_LAT];

   logic [7:0]  hold_x_q;
   logic [6:0]  hold_y_q;
   logic [8:0]  hold_colour_q;

   logic [3:0]  last_col_d;
   logic [3:0]  last_row_d;
   logic [8:0]  pix_x_d;
   logic [7:0]  pix_y_d;
   logic        pix_valid_d;
   logic        issuing_d;
   logic [14:0] addr_calc_d;
   logic        exit_valid_d;

   // Odd directions are diagonal and need the full bounding box.
   always_comb begin
      last_col_d = 4'd13;
      last_row_d = 4'd7;
      if (dir_q[0]) begin
         last_col_d = 4'd14;
         last_row_d = 4'd14;
      end else if (dir_q[1]) begin
         last_col_d = 4'd7;
         last_row_d = 4'd13;
      end
   end

   assign pix_x_d     = {1'b0, x0_q} + 9'(col_q);
   assign pix_y_d     = {1'b0, y0_q} + 8'(row_q);
   assign pix_valid_d = (pix_x_d < 9'(MAP_W)) && (pix_y_d < 8'(MAP_H));
   assign issuing_d   = (state_q == ISSUE);
   assign addr_calc_d = 15'(pix_x_d) + 15'(MAP_W) * 15'(pix_y_d);
   assign oMapAddr    = (issuing_d && pix_valid_d) ? addr_calc_d : 15'd0;

   assign exit_valid_d = pv_q[MEM_LAT-1];

   // Outputs follow the exiting pipeline entry in the cycle its map data arrives.
   always_comb begin
      oPlot   = exit_valid_d;
      oX      = hold_x_q;
      oY      = hold_y_q;
      oColour = hold_colour_q;
      if (exit_valid_d) begin
         oX      = px_q[MEM_LAT-1];
         oY      = py_q[MEM_LAT-1];
         oColour = iMapData;
      end
   end

   assign oBusy = (state_q == ISSUE) || (state_q == DRAIN);
   assign oDone = (state_q == DONE);

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q       <= IDLE;
         x0_q          <= '0;
         y0_q          <= '0;
         dir_q         <= '0;
         col_q         <= '0;
         row_q         <= '0;
         drain_q       <= '0;
         hold_x_q      <= '0;
         hold_y_q      <= '0;
         hold_colour_q <= '0;
         for (int i = 0; i < MEM_LAT; i++) begin
            pv_q[i] <= 1'b0;
            px_q[i] <= '0;
            py_q[i] <= '0;
         end
      end else begin
         pv_q[0] <= issuing_d && pix_valid_d;
         px_q[0] <= pix_x_d[7:0];
         py_q[0] <= pix_y_d[6:0];
         for (int i = 1; i < MEM_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            px_q[i] <= px_q[i-1];
            py_q[i] <= py_q[i-1];
         end

         if (exit_valid_d) begin
            hold_x_q      <= px_q[MEM_LAT-1];
            hold_y_q      <= py_q[MEM_LAT-1];
            hold_colour_q <= iMapData;
         end

         unique case (state_q)
            IDLE: begin
               if (iStart) begin
                  x0_q    <= iX;
                  y0_q    <= iY;
                  dir_q   <= iDir;
                  col_q   <= '0;
                  row_q   <= '0;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (col_q == last_col_d) begin
                  col_q <= '0;
                  if (row_q == last_row_d) begin
                     drain_q <= '0;
                     state_q <= DRAIN;
                  end else begin
                     row_q <= row_q + 4'd1;
                  end
               end else begin
                  col_q <= col_q + 4'd1;
               end
            end
            DRAIN: begin
               if (drain_q == 2'(MEM_LAT - 1)) begin
                  state_q <= DONE;
               end else begin
                  drain_q <= drain_q + 2'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_erase_car.sv
// Directed bench for erase_car: map model returns address[8:0] after a fixed read latency.
module tb_erase_car;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        iReset;
   logic        iStart;
   logic [7:0]  iX;
   logic [6:0]  iY;
   logic [2:0]  iDir;
   logic [8:0]  iMapData;
   logic [14:0] oMapAddr;
   logic [7:0]  oX;
   logic [6:0]  oY;
   logic [8:0]  oColour;
   logic        oPlot;
   logic        oBusy;
   logic        oDone;

   always #5 clk = ~clk;

   erase_car #(.MAP_W(160), .MAP_H(120), .MEM_LAT(LAT)) dut (
      .iClock  (clk),
      .iReset  (iReset),
      .iStart  (iStart),
      .iX      (iX),
      .iY      (iY),
      .iDir    (iDir),
      .iMapData(iMapData),
      .oMapAddr(oMapAddr),
      .oX      (oX),
      .oY      (oY),
      .oColour (oColour),
      .oPlot   (oPlot),
      .oBusy   (oBusy),
      .oDone   (oDone)
   );

   // Map memory model: data = address[8:0], LAT cycles after the address.
   logic [14:0] mem_pipe [LAT];
   initial for (int i = 0; i < LAT; i++) mem_pipe[i] = '0;
   always @(posedge clk) begin
      mem_pipe[0] <= oMapAddr;
      for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
   end
   assign iMapData = mem_pipe[LAT-1][8:0];

   typedef struct {
      int x;
      int y;
      int col;
      int cyc;
   } plot_t;

   plot_t pq[$];
   int    addr_log [600];
   bit    busy_log [600];
   int    cyc = 0;
   bit    arm = 1'b0;
   int    plot_count = 0;
   int    done_count = 0;
   int    done_cyc = -1;
   int    both = 0;
   int    checks = 0;
   int    errors = 0;

   // Cycle 1 is the cycle after the edge that accepts iStart.
   always @(posedge clk) begin
      plot_t p;
      #1;
      if (arm) begin
         cyc = 1;
         arm = 1'b0;
      end else begin
         cyc++;
      end
      if (cyc < 600) begin
         addr_log[cyc] = int'(oMapAddr);
         busy_log[cyc] = oBusy;
      end
      if (oPlot) begin
         p.x = int'(oX);
         p.y = int'(oY);
         p.col = int'(oColour);
         p.cyc = cyc;
         pq.push_back(p);
         plot_count++;
      end
      if (oDone) begin
         done_count++;
         done_cyc = cyc;
      end
      if (oPlot && oDone) both++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      pq.delete();
      plot_count = 0;
      done_count = 0;
      done_cyc   = -1;
      both       = 0;
      foreach (addr_log[i]) addr_log[i] = -1;
      foreach (busy_log[i]) busy_log[i] = 1'b0;
   endtask

   // Call at a negedge; returns at the negedge of cycle 1.
   task automatic start_run(input int x, input int y, input int d);
      clear_logs();
      iX     = 8'(x);
      iY     = 7'(y);
      iDir   = 3'(d);
      iStart = 1'b1;
      arm    = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
   endtask

   task automatic wait_cyc(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic check_run(input int x, input int y, input int d, input int exp_plots);
      int w, h, n, k, px, py, idx;
      bit v;
      if (d % 2 == 1) begin w = 15; h = 15; end
      else if (d == 0 || d == 4) begin w = 14; h = 8; end
      else begin w = 8; h = 14; end
      n = w * h;
      k = 0;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            px  = x + c;
            py  = y + r;
            idx = r * w + c;
            v   = (px < 160) && (py < 120);
            chk("addr", addr_log[1 + idx], v ? (px + 160 * py) : 0);
            if (v) begin
               if (k < pq.size()) begin
                  chk("plot_x", pq[k].x, px);
                  chk("plot_y", pq[k].y, py);
                  chk("plot_cyc", pq[k].cyc, 1 + idx + LAT);
                  chk("plot_colour", pq[k].col, (px + 160 * py) % 512);
               end
               k++;
            end
         end
      end
      chk("plot_count", plot_count, exp_plots);
      chk("done_count", done_count, 1);
      chk("done_cyc", done_cyc, n + LAT + 1);
      chk("busy_first", int'(busy_log[1]), 1);
      chk("busy_last", int'(busy_log[n + LAT]), 1);
      chk("busy_done", int'(busy_log[n + LAT + 1]), 0);
      chk("plot_and_done", both, 0);
      $display("run x=%0d y=%0d dir=%0d plots=%0d done_cyc=%0d", x, y, d, plot_count, done_cyc);
   endtask

   initial begin
      iReset = 1'b1;
      iStart = 1'b0;
      iX = '0;
      iY = '0;
      iDir = '0;
      repeat (3) @(negedge clk);
      iReset = 1'b0;
      @(negedge clk);
      chk("rst_plot", int'(oPlot), 0);
      chk("rst_done", int'(oDone), 0);
      chk("rst_busy", int'(oBusy), 0);
      chk("rst_x", int'(oX), 0);
      chk("rst_y", int'(oY), 0);
      chk("rst_colour", int'(oColour), 0);
      chk("rst_addr", int'(oMapAddr), 0);

      // Straight, dir 0
      @(negedge clk);
      start_run(10, 20, 0);
      wait_cyc(112 + LAT + 2);
      check_run(10, 20, 0, 112);
      chk("straight_first_addr", addr_log[1], 3210);
      chk("straight_first_colour", (pq.size() > 0) ? pq[0].col : -1, 138);
      chk("straight_last_addr", addr_log[112], 4343);
      chk("straight_done_cyc", done_cyc, 115);

      // Vertical, dir 6
      @(negedge clk);
      start_run(0, 0, 6);
      wait_cyc(112 + LAT + 2);
      check_run(0, 0, 6, 112);
      chk("vert_addr7", addr_log[8], 7);
      chk("vert_addr8", addr_log[9], 160);
      chk("vert_last_addr", addr_log[112], 2087);

      // Diagonal at the bottom-right corner
      @(negedge clk);
      start_run(145, 105, 3);
      wait_cyc(225 + LAT + 2);
      check_run(145, 105, 3, 225);
      chk("diag_last_addr", addr_log[225], 19199);
      chk("diag_done_cyc", done_cyc, 228);

      // Clipping on both axes
      @(negedge clk);
      start_run(150, 115, 0);
      wait_cyc(112 + LAT + 2);
      check_run(150, 115, 0, 50);
      chk("clip_addr_x160", addr_log[11], 0);
      chk("clip_done_cyc", done_cyc, 115);

      // Re-pulsed iStart during ISSUE and DONE is ignored
      @(negedge clk);
      start_run(40, 30, 0);
      wait_cyc(5);
      iX = 8'd100; iY = 7'd100; iDir = 3'd3; iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      wait_cyc(115);
      iX = 8'd7; iY = 7'd9; iDir = 3'd1; iStart = 1'b1;
      @(negedge clk);
      check_run(40, 30, 0, 112);
      start_run(60, 50, 2);
      wait_cyc(112 + LAT + 2);
      check_run(60, 50, 2, 112);

      // Reset in the middle of a diagonal erase
      @(negedge clk);
      start_run(145, 105, 3);
      wait_cyc(40);
      iReset = 1'b1;
      @(negedge clk);
      iReset = 1'b0;
      chk("abort_plot", int'(oPlot), 0);
      chk("abort_busy", int'(oBusy), 0);
      chk("abort_done", int'(oDone), 0);
      clear_logs();
      wait_cyc(300);
      chk("abort_plots_after", plot_count, 0);
      chk("abort_dones_after", done_count, 0);

      // Fresh erase after the abort
      @(negedge clk);
      start_run(10, 20, 0);
      wait_cyc(112 + LAT + 2);
      check_run(10, 20, 0, 112);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/erase_car.md
Name: erase_car

Overview:
- Restores the background under a car's previous footprint before the car is redrawn at its new location.
- Consumes the registered old position and direction (RX/RY/Rdir) latched by the car-draw stage.
- Reads the background map memory one pixel per cycle and emits VGA plot requests carrying the map colour.
- Sits between the game controller (issues erase, then draw) and the VGA adapter plot mux.

Parameters:
- MAP_W, 160, screen/map width in pixels; address = x + MAP_W*y
- MAP_H, 120, screen height; pixels with y >= MAP_H are clipped
- MEM_LAT, 2, synchronous read latency of the map memory in cycles (1..3 supported)

Ports:
- iClock  in  1  system clock
- iReset  in  1  synchronous, active-high reset
- iStart  in  1  one-cycle pulse; sampled only in IDLE
- iX  in  8  old upper-left x
- iY  in  7  old upper-left y
- iDir  in  3  old direction 0..7
- iMapData  in  9  map memory read data {R,G,B} 3 bits each, valid MEM_LAT cycles after address
- oMapAddr  out  15  map memory read address
- oX  out  8  VGA pixel x
- oY  out  7  VGA pixel y
- oColour  out  9  VGA pixel colour
- oPlot  out  1  VGA write strobe
- oBusy  out  1  high from the cycle after iStart accepted until oDone
- oDone  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, iReset=1 at a clock edge): state IDLE; oPlot=0, oDone=0, oBusy=0, oX=0, oY=0, oColour=0, oMapAddr=0; pipeline valid bits cleared. Reset mid-operation aborts immediately, with no further oPlot and no oDone.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: on iStart=1, latch iX/iY/iDir; next state ISSUE. All other input changes are ignored.
- Footprint, selected from the latched direction:
  - dir 0/4: 14 wide x 8 tall, 112 px.
  - dir 2/6: 8 wide x 14 tall, 112 px.
  - dir odd: 15 x 15 box, 225 px.
- Scan order: column counter c (fast) and row counter r (slow), both starting at 0, row-major. Pixel is x = X + c, y = Y + r, computed at 9/8 bits so overflow is detectable. No divide/modulo.
- ISSUE: one pixel per cycle. oMapAddr = x + MAP_W*y (combinational from the counters, 15 bits; max 19199).
  - The pixel's (x, y, valid) enters a MEM_LAT-deep shift pipeline.
  - valid = (x < MAP_W) && (y < MAP_H).
  - Clipped pixels still consume their cycle, so timing is independent of clipping. Their address is forced to 0.
- After the last pixel is issued: next state DRAIN.
- Output stage: when a pipeline entry exits with valid=1, then in that same cycle oPlot=1, oX/oY = the pipelined coordinates, and oColour = iMapData. Otherwise oPlot=0 and oX/oY/oColour hold their values.
- DRAIN: lasts MEM_LAT cycles, until the pipeline is empty; then DONE.
- DONE: oDone=1 for one cycle; next state IDLE. oBusy=0 in the DONE cycle.
- Timing, with iStart sampled at edge 0:
  - first address presented in cycle 1; first oPlot in cycle 1+MEM_LAT;
  - for N pixels, last oPlot in cycle N+MEM_LAT and oDone in cycle N+MEM_LAT+1.
  - Straight (MEM_LAT=2): oDone in cycle 115. Diagonal: oDone in cycle 228.
- iStart while not in IDLE (including the DONE cycle) is ignored, not queued.
- oPlot and oDone never assert in the same cycle.

Test Plan:
- Straight dir=0, iX=10, iY=20, MEM_LAT=2, map data = address[8:0] -> 112 oPlot pulses in cycles 3..114. First pixel is (10,20) at addr 3210, colour 3210 mod 512 = 138. Last pixel is (23,27) at addr 4343. oDone in cycle 115 only.
- Vertical dir=6, iX=0, iY=0 -> first addresses 0,1,...,7 then 160. Last pixel is (7,13) at addr 2087. 112 plots total.
- Diagonal dir=3, iX=145, iY=105 -> 225 issue cycles; x clipped above 159, y clipped above 119. Exactly 15x15 = 225 plots (145+14=159, 105+14=119). Last pixel is addr 19199. oDone in cycle 228.
- Clipping: dir=0, iX=150, iY=115 -> only x 150..159 and y 115..119 are plotted: 50 oPlot pulses. oDone still in cycle 115. No plot with x >= 160 or y >= 120.
- iStart re-pulsed in cycles 5 and 115 with different coordinates -> ignored. Exactly one oDone, and every plot uses the first coordinates. A fresh iStart in cycle 116 is accepted.
- iReset=1 at cycle 40 of a diagonal erase -> from cycle 41, oPlot=0, oBusy=0, and no oDone. A subsequent iStart runs a complete, correct erase.
